// File: rtl/sat_pkg.sv
// sat_pkg: shared repeat-FSM encodings, default timing constants and a
// small width helper for the saturating up/down register driver.
package sat_pkg;

    // Repeat FSM states shared by every button channel.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_e;

    // Default timing in clk cycles.
    localparam int unsigned DEF_WIDTH           = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    // Larger of two counts, used to size a counter shared by two phases.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: one push-button channel. Synchronizes a raw active-low button,
// debounces it, and turns a held press into a first step followed by
// delayed auto-repeat steps.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   btn_n_i   raw active-low button, asynchronous to clk
//   step_c_o  one-cycle step request (combinational from registered state)
module btn_repeat
    import sat_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_i,
    output logic step_c_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [1:0]       sync_q;
    logic             lvl_q, lvl_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    rep_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pressed;

    assign pressed = ~lvl_q;

    // Two-flop synchronizer; released (1) out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

    // Debouncer: count consecutive samples that disagree with the level.
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        if (sync_q[1] != lvl_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q    <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            lvl_q    <= lvl_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Repeat FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Repeat FSM: next state and phase counter; release always returns to IDLE.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                    state_d = S_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            S_REPEAT: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end else if (rpt_cnt_q != RPT_W'(REPEAT_PERIOD - 1)) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Repeat FSM: step on press, at end of delay, and at each period end.
    always_comb begin
        step_c_o = 1'b0;
        case (state_q)
            S_IDLE:   step_c_o = pressed;
            S_DELAY:  step_c_o = pressed && (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1));
            S_REPEAT: step_c_o = pressed && (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1));
            default:  step_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sat_counter_driver.sv
// sat_counter_driver: saturating up/down register driven by two debounced,
// auto-repeating active-low buttons. Owns all clamping of regs.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   btn_inc_n  raw increment button, active-low
//   btn_dec_n  raw decrement button, active-low
//   regs       saturating register value, width+1 bits
//   sat_hit    one-cycle pulse when a step is refused at a limit
module sat_counter_driver
    import sat_pkg::*;
#(
    parameter int unsigned width           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           btn_inc_n,
    input  logic           btn_dec_n,
    output logic [width:0] regs,
    output logic           sat_hit
);

    localparam int unsigned REG_W = width + 1;

    logic           inc_step_c;
    logic           dec_step_c;
    logic [width:0] regs_d;
    logic           sat_hit_d;

    btn_repeat #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_inc (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_n_i  (btn_inc_n),
        .step_c_o (inc_step_c)
    );

    btn_repeat #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_dec (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_n_i  (btn_dec_n),
        .step_c_o (dec_step_c)
    );

    // Arbitration and clamping; coincident inc and dec steps cancel silently.
    always_comb begin
        regs_d    = regs;
        sat_hit_d = 1'b0;
        if (inc_step_c && !dec_step_c) begin
            if (regs == '1) begin
                sat_hit_d = 1'b1;
            end else begin
                regs_d = regs + REG_W'(1);
            end
        end else if (dec_step_c && !inc_step_c) begin
            if (regs == '0) begin
                sat_hit_d = 1'b1;
            end else begin
                regs_d = regs - REG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs    <= '0;
            sat_hit <= 1'b0;
        end else begin
            regs    <= regs_d;
            sat_hit <= sat_hit_d;
        end
    end

endmodule

// File: tb/tb_sat_counter_driver.sv
// tb_sat_counter_driver: scenario tasks plus randomized traffic, checked each
// cycle against a behavioural model built from the debounce window and the
// step schedule (press, +REPEAT_DELAY, then every REPEAT_PERIOD).
module tb_sat_counter_driver;

    localparam int W    = 4;
    localparam int RW   = W + 1;
    localparam int DB   = 4;
    localparam int RD   = 16;
    localparam int RP   = 4;
    localparam int RMAX = (1 << RW) - 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         btn_inc_n;
    logic         btn_dec_n;
    logic [W:0]   regs;
    logic         sat_hit;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sat_counter_driver #(
        .width           (W),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_inc_n (btn_inc_n),
        .btn_dec_n (btn_dec_n),
        .regs      (regs),
        .sat_hit   (sat_hit)
    );

    // ---------------- reference model ----------------
    // m_hist bit j holds the raw level sampled j edges ago. The debounced
    // level flips once the raw samples from DB+1 down to 2 edges ago (the
    // synchronizer delay) all disagree with it.
    logic [DB+1:0] m_hist [2];
    logic          m_lvl  [2];
    int            m_fall [2];
    int            m_t;
    int            m_regs;
    logic          m_sat;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = '1;
            m_lvl[b]  = 1'b1;
            m_fall[b] = -1000000;
        end
        m_t    = 0;
        m_regs = 0;
        m_sat  = 1'b0;
    endfunction

    function automatic void model_edge(input logic inc_raw, input logic dec_raw);
        logic raw [2];
        bit   stp [2];
        int   d;
        raw[0] = inc_raw;
        raw[1] = dec_raw;
        for (int b = 0; b < 2; b++) begin
            stp[b] = 1'b0;
            if (!m_lvl[b]) begin
                d = m_t - m_fall[b];
                if (d == 0 || (d >= RD && ((d - RD) % RP) == 0)) stp[b] = 1'b1;
            end
        end
        m_sat = 1'b0;
        if (stp[0] && !stp[1]) begin
            if (m_regs == RMAX) m_sat = 1'b1;
            else m_regs = m_regs + 1;
        end else if (stp[1] && !stp[0]) begin
            if (m_regs == 0) m_sat = 1'b1;
            else m_regs = m_regs - 1;
        end
        m_t = m_t + 1;
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][DB:0], raw[b]};
            if (m_hist[b][DB+1:2] == {DB{~m_lvl[b]}}) begin
                m_lvl[b] = ~m_lvl[b];
                if (!m_lvl[b]) m_fall[b] = m_t;
            end
        end
    endfunction

    // Drive inputs at the falling edge, advance the model at the rising edge.
    task automatic drive_cycle(input logic inc, input logic dec);
        btn_inc_n = inc;
        btn_dec_n = dec;
        @(posedge clk);
        if (reset_n) model_edge(inc, dec);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        btn_inc_n = 1'b1;
        btn_dec_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            btn_inc_n = 1'($urandom_range(0, 1));
            btn_dec_n = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (regs !== '0 || sat_hit !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d regs=%0d sat_hit=%b want regs=0 sat_hit=0", i, regs, sat_hit);
            end
        end
        btn_inc_n = 1'b1;
        btn_dec_n = 1'b1;
        reset_n   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat || regs !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
        end
    endtask

    task automatic test_single_press();
        int first;
        for (int pass = 0; pass < 2; pass++) begin
            first = -1;
            for (int i = 1; i <= 30; i++) begin
                if (pass == 0) drive_cycle((i <= 10) ? 1'b0 : 1'b1, 1'b1);
                else           drive_cycle(1'b1, (i <= 10) ? 1'b0 : 1'b1);
                n_vec++;
                if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                    n_err++;
                    $display("FAIL single_press pass=%0d cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", pass, i, regs, sat_hit, m_regs, m_sat);
                end
                if (first < 0 && regs == ((pass == 0) ? RW'(1) : RW'(0)) && i > 1) first = i;
            end
            n_vec++;
            if (first != 7) begin
                n_err++;
                $display("FAIL single_press_latency pass=%0d edges=%0d want 7", pass, first);
            end
            n_vec++;
            if (regs !== ((pass == 0) ? RW'(1) : RW'(0))) begin
                n_err++;
                $display("FAIL single_press_final pass=%0d regs=%0d want %0d", pass, regs, (pass == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_bounce();
        int gap;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b0, 1'b1);
                n_vec++;
                if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                    n_err++;
                    $display("FAIL bounce glitch=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", g, regs, sat_hit, m_regs, m_sat);
                end
            end
            gap = 2 + int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) drive_cycle(1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1);
        n_vec++;
        if (regs !== '0 || m_regs != 0) begin
            n_err++;
            $display("FAIL bounce_final regs=%0d model=%0d want 0", regs, m_regs);
        end
    endtask

    task automatic test_auto_repeat();
        int         exp_e [6] = '{7, 23, 27, 31, 35, 39};
        int         edges [$];
        logic [W:0] prev;
        prev = regs;
        // Held 36 cycles so the debounced release lands before the +36 step.
        for (int i = 1; i <= 56; i++) begin
            drive_cycle((i <= 36) ? 1'b0 : 1'b1, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL auto_repeat cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
            if (regs !== prev) edges.push_back(i);
            prev = regs;
        end
        n_vec++;
        if (edges.size() != 6 || regs !== RW'(6)) begin
            n_err++;
            $display("FAIL auto_repeat_count steps=%0d regs=%0d want steps=6 regs=6", edges.size(), regs);
        end
        for (int k = 0; k < 6 && k < edges.size(); k++) begin
            n_vec++;
            if (edges[k] != exp_e[k]) begin
                n_err++;
                $display("FAIL auto_repeat_edge k=%0d edge=%0d want %0d", k, edges[k], exp_e[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int hits;
        for (int dir = 0; dir < 2; dir++) begin
            // Long hold drives regs to the limit in this direction.
            for (int i = 1; i <= 160; i++) begin
                if (dir == 0) drive_cycle((i <= 140) ? 1'b0 : 1'b1, 1'b1);
                else          drive_cycle(1'b1, (i <= 140) ? 1'b0 : 1'b1);
                n_vec++;
                if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                    n_err++;
                    $display("FAIL sat_preload dir=%0d cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", dir, i, regs, sat_hit, m_regs, m_sat);
                end
            end
            hits = 0;
            for (int i = 1; i <= 30; i++) begin
                if (dir == 0) drive_cycle((i <= 10) ? 1'b0 : 1'b1, 1'b1);
                else          drive_cycle(1'b1, (i <= 10) ? 1'b0 : 1'b1);
                n_vec++;
                if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                    n_err++;
                    $display("FAIL sat_press dir=%0d cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", dir, i, regs, sat_hit, m_regs, m_sat);
                end
                if (sat_hit === 1'b1) hits++;
            end
            n_vec++;
            if (hits != 1 || regs !== ((dir == 0) ? RW'(RMAX) : RW'(0))) begin
                n_err++;
                $display("FAIL sat_limit dir=%0d hits=%0d regs=%0d want hits=1 regs=%0d", dir, hits, regs, (dir == 0) ? RMAX : 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        int hits;
        int first;
        // Preload to 10: steps land at edges 7, 23, 27, ..., 55.
        for (int i = 1; i <= 72; i++) begin
            drive_cycle((i <= 52) ? 1'b0 : 1'b1, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL simul_preload cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
        end
        n_vec++;
        if (regs !== RW'(10)) begin
            n_err++;
            $display("FAIL simul_preload_final regs=%0d want 10", regs);
        end
        hits = 0;
        for (int i = 1; i <= 30; i++) begin
            drive_cycle((i <= 10) ? 1'b0 : 1'b1, (i <= 10) ? 1'b0 : 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL simul_both cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
            if (sat_hit === 1'b1) hits++;
        end
        n_vec++;
        if (regs !== RW'(10) || hits != 0) begin
            n_err++;
            $display("FAIL simul_cancel regs=%0d sat_hits=%0d want regs=10 sat_hits=0", regs, hits);
        end
        // Reset while the inc channel is auto-repeating.
        for (int i = 1; i <= 30; i++) begin
            drive_cycle(1'b0, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL reset_repeat_hold cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (regs !== '0 || sat_hit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async regs=%0d sat_hit=%b want regs=0 sat_hit=0", regs, sat_hit);
        end
        @(negedge clk);
        reset_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            drive_cycle(1'b0, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL reset_rearm cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
            if (first < 0 && regs == RW'(1)) first = i;
        end
        n_vec++;
        if (first != 7) begin
            n_err++;
            $display("FAIL reset_rearm_latency edges=%0d want 7", first);
        end
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic inc;
        logic dec;
        int   len;
        for (int seg = 0; seg < 60; seg++) begin
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                drive_cycle(inc, dec);
                n_vec++;
                if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                    n_err++;
                    $display("FAIL random seg=%0d cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", seg, i, regs, sat_hit, m_regs, m_sat);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            drive_cycle(1'b1, 1'b1);
            n_vec++;
            if (regs !== RW'(m_regs) || sat_hit !== m_sat) begin
                n_err++;
                $display("FAIL random_drain cyc=%0d regs=%0d sat_hit=%b want regs=%0d sat_hit=%b", i, regs, sat_hit, m_regs, m_sat);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_inc_n = 1'b1;
        btn_dec_n = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_saturation();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
